// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control sequencer for the stopwatch counter/display datapath.
// Synchronizes and debounces the board inputs. Runs the RUN/PAUSE/ADJUST state
// machine. Issues registered one-cycle command pulses to the min:sec counter.
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   btn_pause, btn_reset  raw push buttons (async, active-high, debounced here)
//   sw_adj, sw_sel        raw switches (sync only); sw_sel 0=minutes 1=seconds
//   cnt_en                pulse: advance counter one second
//   cnt_clr               pulse: clear counter to 00:00
//   adj_min_inc           pulse: increment minutes field
//   adj_sec_inc           pulse: increment seconds field
//   blink                 blink phase for the selected field, 0 outside ADJUST
//   state                 00=RUN 01=PAUSE 10=ADJUST
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned ADJ_DIV   = 50_000_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       adj_min_inc,
    output logic       adj_sec_inc,
    output logic       blink,
    output logic [1:0] state
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned ADJ_W  = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
    localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_PAUSE  = 2'b01,
        ST_ADJUST = 2'b10
    } state_e;

    // Synchronizer bit order: {sw_sel, sw_adj, btn_reset, btn_pause}
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;

    // Debouncer state for the two buttons (index 0 = pause, 1 = reset)
    logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]           db_lvl_q, db_lvl_d;
    logic [1:0]           db_prev_q, db_prev_d;
    logic [1:0]           press_c;

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [ADJ_W-1:0]  adj_cnt_q, adj_cnt_d;
    logic              tick_c, adj_tick_c;

    state_e state_q, state_d;
    logic   resume_q, resume_d;

    logic cnt_en_q, cnt_en_d;
    logic cnt_clr_q, cnt_clr_d;
    logic adj_min_q, adj_min_d;
    logic adj_sec_q, adj_sec_d;
    logic blink_q, blink_d;

    logic pause_press_c, clr_press_c, adj_s_c, sel_s_c;

    // Two-flop synchronizer stage inputs
    always_comb begin
        sync1_d = {sw_sel, sw_adj, btn_reset, btn_pause};
        sync2_d = sync1_q;
    end

    assign adj_s_c = sync2_q[2];
    assign sel_s_c = sync2_q[3];

    // Debounce: level follows the synced input only after DB_CYCLES
    // consecutive differing samples; any sample equal to the level restarts it.
    always_comb begin
        db_cnt_d  = db_cnt_q;
        db_lvl_d  = db_lvl_q;
        db_prev_d = db_lvl_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_lvl_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                db_lvl_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Press = rising edge of the debounced level; releases are ignored
    assign press_c       = db_lvl_q & ~db_prev_q;
    assign pause_press_c = press_c[0];
    assign clr_press_c   = press_c[1];

    // Prescalers: 1 Hz tick only advances in RUN, adjust tick free-runs
    always_comb begin
        tick_c     = (state_q == ST_RUN) && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        adj_tick_c = (adj_cnt_q == ADJ_W'(ADJ_DIV - 1));
        tick_cnt_d = tick_cnt_q;
        if (clr_press_c) begin
            tick_cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
        end
        adj_cnt_d = adj_tick_c ? '0 : adj_cnt_q + ADJ_W'(1);
    end

    // Next state: adjust entry beats a same-cycle pause press
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        if (adj_s_c && (state_q != ST_ADJUST)) begin
            state_d  = ST_ADJUST;
            resume_d = (state_q == ST_PAUSE);
        end else if ((state_q == ST_ADJUST) && !adj_s_c) begin
            state_d = resume_q ? ST_PAUSE : ST_RUN;
        end else if (pause_press_c) begin
            case (state_q)
                ST_RUN:    state_d  = ST_PAUSE;
                ST_PAUSE:  state_d  = ST_RUN;
                ST_ADJUST: resume_d = ~resume_q;
                default:   state_d  = ST_RUN;
            endcase
        end
    end

    // Pulse and blink outputs; a clear suppresses every other pulse
    always_comb begin
        cnt_clr_d = clr_press_c;
        cnt_en_d  = tick_c && !clr_press_c;
        adj_min_d = adj_tick_c && (state_q == ST_ADJUST) && !sel_s_c && !clr_press_c;
        adj_sec_d = adj_tick_c && (state_q == ST_ADJUST) && sel_s_c && !clr_press_c;
        blink_d   = blink_q;
        if (state_d != ST_ADJUST) begin
            blink_d = 1'b0;
        end else if ((state_q == ST_ADJUST) && adj_tick_c) begin
            blink_d = ~blink_q;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_cnt_q   <= '0;
            db_lvl_q   <= '0;
            db_prev_q  <= '0;
            tick_cnt_q <= '0;
            adj_cnt_q  <= '0;
            cnt_en_q   <= 1'b0;
            cnt_clr_q  <= 1'b0;
            adj_min_q  <= 1'b0;
            adj_sec_q  <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_cnt_q   <= db_cnt_d;
            db_lvl_q   <= db_lvl_d;
            db_prev_q  <= db_prev_d;
            tick_cnt_q <= tick_cnt_d;
            adj_cnt_q  <= adj_cnt_d;
            cnt_en_q   <= cnt_en_d;
            cnt_clr_q  <= cnt_clr_d;
            adj_min_q  <= adj_min_d;
            adj_sec_q  <= adj_sec_d;
            blink_q    <= blink_d;
        end
    end

    assign cnt_en      = cnt_en_q;
    assign cnt_clr     = cnt_clr_q;
    assign adj_min_inc = adj_min_q;
    assign adj_sec_inc = adj_sec_q;
    assign blink       = blink_q;
    assign state       = 2'(state_q);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=10, ADJ_DIV=4, DB_CYCLES=3.
// Expected pulse events {cnt_en,cnt_clr,adj_min_inc,adj_sec_inc} are queued
// with the clock edge they must follow; every cycle the pulse vector is
// compared to the queue head (or to zero when no event is due).
module tb_stopwatch_ctrl;

    localparam int unsigned TICK_DIV  = 10;
    localparam int unsigned ADJ_DIV   = 4;
    localparam int unsigned DB_CYCLES = 3;

    localparam logic [3:0] P_EN  = 4'b1000;
    localparam logic [3:0] P_CLR = 4'b0100;
    localparam logic [3:0] P_MIN = 4'b0010;
    localparam logic [3:0] P_SEC = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_pause = 1'b0;
    logic       btn_reset = 1'b0;
    logic       sw_adj = 1'b0;
    logic       sw_sel = 1'b0;
    logic       cnt_en, cnt_clr, adj_min_inc, adj_sec_inc, blink;
    logic [1:0] state;
    logic [3:0] pulses;

    typedef struct {
        int         cyc;
        logic [3:0] p;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   r_edge = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    stopwatch_ctrl #(
        .TICK_DIV (TICK_DIV),
        .ADJ_DIV  (ADJ_DIV),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_pause  (btn_pause),
        .btn_reset  (btn_reset),
        .sw_adj     (sw_adj),
        .sw_sel     (sw_sel),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .adj_min_inc(adj_min_inc),
        .adj_sec_inc(adj_sec_inc),
        .blink      (blink),
        .state      (state)
    );

    assign pulses = {cnt_en, cnt_clr, adj_min_inc, adj_sec_inc};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [3:0] p);
        exp_t e;
        e.cyc = c;
        e.p   = p;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (state !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_state: got %b expected 00", state);
        end
        n_checks++;
        if (pulses !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_pulses: got %b expected 0000", pulses);
        end
        n_checks++;
        if (blink !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_blink: got %b expected 0", blink);
        end
        rst_n  = 1'b1;
        r_edge = cyc;
    endtask

    // Ten ticks in 100 cycles from reset release
    task automatic test_free_run();
        logic [3:0] exp_p;
        for (int i = 1; i <= 10; i++) push(r_edge + 10 * i, P_EN);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            exp_p = 4'b0000;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_p = sb[0].p;
                void'(sb.pop_front());
            end
            n_checks++;
            if (pulses !== exp_p) begin
                n_errors++;
                $display("FAIL free_run pulses: got %b expected %b at cycle %0d", pulses, exp_p, cyc);
            end
        end
        n_checks++;
        if (state !== 2'b00 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL free_run end: state %b pending %0d, expected 00 and 0", state, sb.size());
        end
        sb.delete();
    endtask

    // Bounced pause press, hold, resume with the remaining count
    task automatic test_pause();
        logic [3:0] exp_p;
        int s;
        s = cyc;
        push(s + 10, P_EN);
        push(s + 43, P_EN);
        push(s + 53, P_EN);
        for (int k = 1; k <= 55; k++) begin
            @(negedge clk);
            exp_p = 4'b0000;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_p = sb[0].p;
                void'(sb.pop_front());
            end
            n_checks++;
            if (pulses !== exp_p) begin
                n_errors++;
                $display("FAIL pause pulses: got %b expected %b at cycle %0d", pulses, exp_p, cyc);
            end
            if (k == 12 || k == 13 || k == 35 || k == 36) begin
                n_checks++;
                if (state !== ((k == 13 || k == 35) ? 2'b01 : 2'b00)) begin
                    n_errors++;
                    $display("FAIL pause state k=%0d: got %b", k, state);
                end
            end
            case (k)
                3, 5, 7, 30: btn_pause = 1'b1;
                4, 6, 20, 40: btn_pause = 1'b0;
                default: ;
            endcase
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL pause leftover: got %0d pending expected 0", sb.size());
        end
        sb.delete();
    endtask

    // RUN -> PAUSE -> ADJUST (seconds, then minutes) -> back to PAUSE
    task automatic test_adjust();
        logic [3:0] exp_p;
        logic       exp_blink;
        int a;
        a = cyc;
        exp_blink = 1'b0;
        btn_pause = 1'b1;
        for (int e = a + 16; e <= a + 48; e++) begin
            if ((e - r_edge) % 4 == 0) push(e, (e <= a + 32) ? P_SEC : P_MIN);
        end
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (cyc >= a + 16 && cyc <= a + 47 && (cyc - r_edge) % 4 == 0) exp_blink = ~exp_blink;
            if (cyc == a + 48) exp_blink = 1'b0;
            exp_p = 4'b0000;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_p = sb[0].p;
                void'(sb.pop_front());
            end
            n_checks++;
            if (pulses !== exp_p) begin
                n_errors++;
                $display("FAIL adjust pulses: got %b expected %b at cycle %0d", pulses, exp_p, cyc);
            end
            n_checks++;
            if (blink !== exp_blink) begin
                n_errors++;
                $display("FAIL adjust blink: got %b expected %b at cycle %0d", blink, exp_blink, cyc);
            end
            if (k == 5 || k == 6 || k == 14 || k == 15 || k == 47 || k == 48) begin
                n_checks++;
                if (state !== ((k == 5) ? 2'b00 : (k == 15 || k == 47) ? 2'b10 : 2'b01)) begin
                    n_errors++;
                    $display("FAIL adjust state k=%0d: got %b", k, state);
                end
            end
            case (k)
                10: btn_pause = 1'b0;
                12: begin sw_adj = 1'b1; sw_sel = 1'b1; end
                30: sw_sel = 1'b0;
                45: sw_adj = 1'b0;
                default: ;
            endcase
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL adjust leftover: got %0d pending expected 0", sb.size());
        end
        sb.delete();
    endtask

    // Clear coinciding with a wrap, then a mid-count clear
    task automatic test_clear();
        logic [3:0] exp_p;
        int c;
        c = cyc;
        btn_pause = 1'b1;
        push(c + 8, P_EN);
        push(c + 18, P_EN);
        push(c + 28, P_CLR);
        push(c + 38, P_EN);
        push(c + 48, P_EN);
        push(c + 50, P_CLR);
        push(c + 60, P_EN);
        for (int k = 1; k <= 62; k++) begin
            @(negedge clk);
            exp_p = 4'b0000;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_p = sb[0].p;
                void'(sb.pop_front());
            end
            n_checks++;
            if (pulses !== exp_p) begin
                n_errors++;
                $display("FAIL clear pulses: got %b expected %b at cycle %0d", pulses, exp_p, cyc);
            end
            if (k == 28 || k == 62) begin
                n_checks++;
                if (state !== 2'b00) begin
                    n_errors++;
                    $display("FAIL clear state k=%0d: got %b expected 00", k, state);
                end
            end
            case (k)
                10: btn_pause = 1'b0;
                22, 44: btn_reset = 1'b1;
                30, 52: btn_reset = 1'b0;
                default: ;
            endcase
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL clear leftover: got %0d pending expected 0", sb.size());
        end
        sb.delete();
    endtask

    // Async reset mid-ADJUST with blink high, then clean restart
    task automatic test_async_reset();
        logic [3:0] exp_p;
        logic       exp_blink;
        int f, e, r2;
        f = cyc;
        exp_blink = 1'b0;
        sw_adj = 1'b1;
        e = f + 4;
        while ((e - r_edge) % 4 != 0) e++;
        push(e, P_MIN);
        for (int k = 1; k <= e - f; k++) begin
            @(negedge clk);
            if (cyc == e) exp_blink = 1'b1;
            exp_p = 4'b0000;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_p = sb[0].p;
                void'(sb.pop_front());
            end
            n_checks++;
            if (pulses !== exp_p || blink !== exp_blink) begin
                n_errors++;
                $display("FAIL areset pre: pulses %b blink %b expected %b %b at cycle %0d",
                         pulses, blink, exp_p, exp_blink, cyc);
            end
        end
        n_checks++;
        if (state !== 2'b10) begin
            n_errors++;
            $display("FAIL areset pre_state: got %b expected 10", state);
        end
        #2 rst_n = 1'b0;
        sw_adj = 1'b0;
        #1;
        n_checks++;
        if (state !== 2'b00 || blink !== 1'b0 || pulses !== 4'b0000) begin
            n_errors++;
            $display("FAIL areset immediate: state %b blink %b pulses %b expected 00 0 0000",
                     state, blink, pulses);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r2 = cyc;
        push(r2 + 10, P_EN);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_p = 4'b0000;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_p = sb[0].p;
                void'(sb.pop_front());
            end
            n_checks++;
            if (pulses !== exp_p) begin
                n_errors++;
                $display("FAIL areset post pulses: got %b expected %b at cycle %0d", pulses, exp_p, cyc);
            end
        end
        n_checks++;
        if (state !== 2'b00 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL areset end: state %b pending %0d expected 00 and 0", state, sb.size());
        end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_pause();
        test_adjust();
        test_clear();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
